// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the serial adder/subtractor:
//   - state_t : FSM state encoding (IDLE, RUN, DONE)
//   - fa_bit  : single-bit full adder returning {carry, sum}
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [1:0] fa_bit(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

endpackage

// File: rtl/serial_adder_param_if.sv
// serial_adder_param_if
//   Request/result bundle for serial_adder_param.
//   master : drives start, sub, a, b, cin; observes busy, done, sum, cout, ovf
//   slave  : the adder side of the same signals
interface serial_adder_param_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, a, b, cin,
                    input  busy, done, sum, cout, ovf);
    modport slave  (input  start, sub, a, b, cin,
                    output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_adder_param_chunk.sv
// adder_chunk
//   Combinational DIGIT-bit ripple adder built from fa_bit.
//   x, y   : operand chunks
//   ci     : carry into bit 0
//   s      : chunk sum
//   co     : carry out of the top bit
//   c_msb  : carry into the top bit (feeds signed overflow on the last chunk)
module adder_chunk
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic c;

    always_comb begin
        s     = '0;
        c     = ci;
        c_msb = ci;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb     = c;  // last iteration leaves carry into bit DIGIT-1
            {c, s[i]} = fa_bit(x[i], y[i], c);
        end
        co = c;
    end
endmodule

// File: rtl/serial_adder_param.sv
// serial_adder_param
//   Multi-cycle adder/subtractor: WIDTH-bit operands processed DIGIT bits
//   per clock, NCHUNK = WIDTH/DIGIT cycles per operation.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : slave side of serial_adder_param_if
//          start/sub/a/b/cin in, busy/done/sum/cout/ovf out
module serial_adder_param
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_param_if.slave  bus
);
    localparam int NCHUNK = WIDTH / DIGIT;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder_param: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] x_chunk, y_chunk, s_chunk;
    logic             co_chunk, cmsb_chunk;

    // Pick the operand chunk addressed by the counter.
    always_comb begin
        x_chunk = '0;
        y_chunk = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (cnt_q == CW'(k)) begin
                x_chunk = op_a_q[k*DIGIT +: DIGIT];
                y_chunk = op_b_q[k*DIGIT +: DIGIT];
            end
        end
    end

    adder_chunk #(.DIGIT(DIGIT)) u_chunk (
        .x     (x_chunk),
        .y     (y_chunk),
        .ci    (carry_q),
        .s     (s_chunk),
        .co    (co_chunk),
        .c_msb (cmsb_chunk)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    // Subtraction becomes a + ~b + 1, so mode needs no storage.
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub ? 1'b1 : bus.cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int k = 0; k < NCHUNK; k++) begin
                    if (cnt_q == CW'(k)) sum_d[k*DIGIT +: DIGIT] = s_chunk;
                end
                carry_d = co_chunk;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = co_chunk;
                    ovf_d   = cmsb_chunk ^ co_chunk;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder_param.sv
module tb_serial_adder_param;
    logic clk = 1'b0;
    logic rst8, rst16;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_adder_param_if #(.WIDTH(8))  if8  ();
    serial_adder_param_if #(.WIDTH(16)) if16 ();

    serial_adder_param #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (if8)
    );

    serial_adder_param #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (if16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w16, input logic st, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        if (w16 != 0) begin
            if16.start = st; if16.a = a; if16.b = b; if16.cin = cin; if16.sub = sub;
        end else begin
            if8.start = st; if8.a = a[7:0]; if8.b = b[7:0]; if8.cin = cin; if8.sub = sub;
        end
    endtask

    // mode 0: plain; 1: scramble inputs mid-run; 2: extra start pulse mid-run
    task automatic run_op(input string tag, input int w16, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, input logic [15:0] esum,
                          input logic ecout, input logic eovf, input int mode);
        int nch, busycnt, donecnt, donek;
        logic [15:0] gsum;
        logic gcout, govf, bsy, dn;
        nch = (w16 != 0) ? 4 : 8;
        busycnt = 0; donecnt = 0; donek = -1;
        gsum = '0; gcout = 1'b0; govf = 1'b0;
        @(negedge clk);
        drive(w16, 1'b1, a, b, cin, sub);
        for (int k = 0; k < nch + 4; k++) begin
            @(negedge clk);
            bsy = (w16 != 0) ? if16.busy : if8.busy;
            dn  = (w16 != 0) ? if16.done : if8.done;
            if (bsy) busycnt++;
            if (dn) begin
                donecnt++;
                donek = k;
                gsum  = (w16 != 0) ? if16.sum : {8'h00, if8.sum};
                gcout = (w16 != 0) ? if16.cout : if8.cout;
                govf  = (w16 != 0) ? if16.ovf : if8.ovf;
            end
            if (k == 0) drive(w16, 1'b0, a, b, cin, sub);
            if (mode == 1 && k == 2) drive(w16, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
            if (mode == 2 && k == 3) drive(w16, 1'b1, 16'h00AA, 16'h0055, 1'b1, 1'b1);
            if (mode == 2 && k == 4) drive(w16, 1'b0, 16'h00AA, 16'h0055, 1'b1, 1'b1);
        end
        chk({tag, ".lat"},   donek, nch);
        chk({tag, ".ndone"}, donecnt, 1);
        chk({tag, ".nbusy"}, busycnt, nch);
        chk({tag, ".sum"},   gsum, esum);
        chk({tag, ".cout"},  gcout, ecout);
        chk({tag, ".ovf"},   govf, eovf);
    endtask

    initial begin
        int donecnt, d1k, d2k;
        logic [15:0] s1, s2;
        logic c1, c2, o2, b2b_busy, b2b_done;

        rst8 = 1'b1; rst16 = 1'b1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        drive(1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst8.outs",  {if8.busy, if8.done, if8.cout, if8.ovf, 8'h0, if8.sum}, 32'h0);
        chk("rst16.outs", {if16.busy, if16.done, if16.cout, if16.ovf, if16.sum}, 32'h0);
        rst8 = 1'b0; rst16 = 1'b0;

        run_op("add_ff_01", 0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        run_op("sub_05_07", 0, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'h00FE, 1'b0, 1'b0, 0);
        run_op("sub_80_01", 0, 16'h0080, 16'h0001, 1'b0, 1'b1, 16'h007F, 1'b1, 1'b1, 0);
        run_op("add_7f_c1", 0, 16'h007F, 16'h0000, 1'b1, 1'b0, 16'h0080, 1'b0, 1'b1, 1);
        run_op("add_12_34", 0, 16'h0012, 16'h0034, 1'b0, 1'b0, 16'h0046, 1'b0, 1'b0, 2);

        // Reset mid-run: partial result discarded, no done afterwards.
        @(negedge clk);
        drive(0, 1'b1, 16'h0012, 16'h0034, 1'b0, 1'b0);
        donecnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (if8.done) donecnt++;
            if (k == 0) drive(0, 1'b0, 16'h0012, 16'h0034, 1'b0, 1'b0);
            if (k == 4) rst8 = 1'b1;
            if (k == 5) begin
                chk("rst_mid.busy", if8.busy, 1'b0);
                chk("rst_mid.sum",  if8.sum, 8'h00);
                rst8 = 1'b0;
            end
        end
        chk("rst_mid.ndone", donecnt, 0);

        run_op("w16_add", 1, 16'h1234, 16'hEDCB, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 0);

        // Back-to-back: start held in the DONE cycle.
        @(negedge clk);
        drive(1, 1'b1, 16'h1234, 16'hEDCB, 1'b1, 1'b0);
        donecnt = 0; d1k = -1; d2k = -1;
        s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0; o2 = 1'b0;
        b2b_busy = 1'b0; b2b_done = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (if16.done) begin
                donecnt++;
                if (donecnt == 1) begin d1k = k; s1 = if16.sum; c1 = if16.cout; end
                else begin d2k = k; s2 = if16.sum; c2 = if16.cout; o2 = if16.ovf; end
            end
            if (k == 5) begin b2b_busy = if16.busy; b2b_done = if16.done; end
            if (k == 0) drive(1, 1'b0, 16'h1234, 16'hEDCB, 1'b1, 1'b0);
            if (k == 4) drive(1, 1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
            if (k == 5) drive(1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        end
        chk("b2b.lat1",  d1k, 4);
        chk("b2b.sum1",  s1, 16'h0000);
        chk("b2b.cout1", c1, 1'b1);
        chk("b2b.busy",  b2b_busy, 1'b1);
        chk("b2b.dlow",  b2b_done, 1'b0);
        chk("b2b.lat2",  d2k, 9);
        chk("b2b.ndone", donecnt, 2);
        chk("b2b.sum2",  s2, 16'h8000);
        chk("b2b.cout2", c2, 1'b0);
        chk("b2b.ovf2",  o2, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
